// File: rtl/dm_pkg.sv
// dm_pkg: shared types and defaults for the data-memory responder.
// Holds FSM/op encodings and the CPU-wide data/address widths.
package dm_pkg;

    localparam int DM_DATA_W = 16;
    localparam int DM_ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    // A request with both re and we high is a store.
    function automatic op_t req_op(logic we);
        return we ? OP_WR : OP_RD;
    endfunction

endpackage

// File: rtl/dm_array.sv
// dm_array: single-port storage, synchronous write, combinational read.
// Ports: clk, we (write strobe), idx (word index), wdata, rdata.
module dm_array
    import dm_pkg::*;
#(
    parameter int DATA_W     = DM_DATA_W,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dm_responder.sv
// dm_responder: fixed-latency data-memory responder for the MEM stage.
// Ports: clk, rst_n, addr, re, we, wrt_data in; rd_data, busy, rdy out.
module dm_responder
    import dm_pkg::*;
#(
    parameter int DATA_W     = DM_DATA_W,
    parameter int ADDR_W     = DM_ADDR_W,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              re,
    input  logic              we,
    input  logic [DATA_W-1:0] wrt_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              rdy
);

    if (LATENCY < 1) begin : g_bad_latency
        $error("dm_responder: LATENCY must be >= 1");
    end

    localparam int CNT_W =
        (LATENCY >= 1) ? $clog2(LATENCY + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT =
        CNT_W'(LATENCY - 1);

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    op_t                   op_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [DATA_W-1:0]     data_q;
    logic [DATA_W-1:0]     arr_rdata;
    logic                  done;
    logic                  arr_we;

    // Upper address bits alias onto the array.
    if (ADDR_W > DEPTH_LOG2) begin : g_alias
        logic unused_addr_hi;
        assign unused_addr_hi =
            ^addr[ADDR_W-1:DEPTH_LOG2];
    end

    // Last BUSY cycle: the access happens on the closing edge.
    assign done   = (state == BUSY) && (cnt == '0);
    assign arr_we = done && (op_q == OP_WR);

    // Stall asserts in the very cycle a request appears.
    assign busy = ((state == IDLE) && (re || we))
                || (state == BUSY);

    dm_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .idx   (idx_q),
        .wdata (data_q),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            op_q    <= OP_RD;
            idx_q   <= '0;
            data_q  <= '0;
            rd_data <= '0;
            rdy     <= 1'b0;
        end else begin
            rdy <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (re || we) begin
                        op_q   <= req_op(we);
                        idx_q  <= addr[DEPTH_LOG2-1:0];
                        data_q <= wrt_data;
                        cnt    <= CNT_INIT;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= RESP;
                        rdy   <= 1'b1;
                        if (op_q == OP_RD) begin
                            rd_data <= arr_rdata;
                        end
                    end
                end
                // Request still visible here is stale.
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: two DUT lanes (LATENCY 4 and 1) with a
// transaction-timed reference model and a per-cycle compare.
module tb_dm_responder;

    bit clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit done [2];

    function automatic void chk(int ln, string nm,
                                logic [31:0] act,
                                logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL lat%0d %s: got %h want %h @%0d",
                     ln, nm, act, exp, cyc);
        end
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int L = (g == 0) ? 4 : 1;

        logic        rst_n    = 1'b0;
        logic        re       = 1'b0;
        logic        we       = 1'b0;
        logic [15:0] addr     = '0;
        logic [15:0] wrt_data = '0;
        logic [15:0] rd_data;
        logic        busy;
        logic        rdy;

        // Current transaction, owned by the driver.
        int          t_start = 0;
        bit          t_wr    = 1'b0;
        int          t_idx   = 0;
        logic [15:0] t_data  = '0;
        bit          active  = 1'b0;

        // Model memory and load result, owned by the compare.
        logic [15:0] mem_m [1024];
        bit          known [1024];
        logic [15:0] exp_rd   = '0;
        bit          rd_known = 1'b1;

        dm_responder #(
            .DATA_W     (16),
            .ADDR_W     (16),
            .DEPTH_LOG2 (10),
            .LATENCY    (L)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .addr     (addr),
            .re       (re),
            .we       (we),
            .wrt_data (wrt_data),
            .rd_data  (rd_data),
            .busy     (busy),
            .rdy      (rdy)
        );

        // Cycle k of a request: busy for k=0..L, rdy at L+1.
        always @(negedge clk) begin
            int k;
            bit eb;
            bit er;
            if (!rst_n) begin
                exp_rd   = '0;
                rd_known = 1'b1;
                chk(L, "rst busy", busy, 0);
                chk(L, "rst rdy", rdy, 0);
                chk(L, "rst rd_data", rd_data, 0);
            end else begin
                k  = cyc - t_start;
                eb = active && (k <= L);
                er = active && (k == L + 1);
                if (er) begin
                    if (t_wr) begin
                        mem_m[t_idx] = t_data;
                        known[t_idx] = 1'b1;
                    end else begin
                        exp_rd   = mem_m[t_idx];
                        rd_known = known[t_idx];
                    end
                end
                chk(L, "busy", busy, eb);
                chk(L, "rdy", rdy, er);
                if (rd_known) begin
                    chk(L, "rd_data", rd_data, exp_rd);
                end
            end
        end

        task automatic launch(bit wr, bit both,
                              logic [15:0] a,
                              logic [15:0] d);
            addr     = a;
            wrt_data = d;
            re       = !wr || both;
            we       = wr;
            t_start  = cyc;
            t_wr     = wr;
            t_idx    = int'(a[9:0]);
            t_data   = d;
            active   = 1'b1;
        endtask

        // Called and returns at posedge+1.
        task automatic access(bit wr, bit both,
                              logic [15:0] a,
                              logic [15:0] d,
                              bit tog, int gap);
            launch(wr, both, a, d);
            for (int i = 0; i < L + 2; i++) begin
                @(posedge clk);
                #1;
                if (tog && i < L + 1) begin
                    addr     = 16'($urandom);
                    wrt_data = 16'($urandom);
                end
            end
            re = 1'b0;
            we = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        endtask

        initial begin
            logic [15:0] a;
            logic [15:0] d;
            bit          wr;
            bit          both;
            bit          tog;
            repeat (3) @(posedge clk);
            #1;
            rst_n = 1'b1;
            @(posedge clk);
            #1;

            access(1, 0, 16'h0010, 16'hBEEF, 0, 0);
            access(0, 0, 16'h0010, 16'h0000, 0, 1);
            chk(L, "lit beef", rd_data, 16'hBEEF);

            access(1, 1, 16'h0003, 16'h1234, 0, 0);
            chk(L, "lit rewe keep", rd_data, 16'hBEEF);
            access(0, 0, 16'h0003, 16'h0000, 0, 0);
            chk(L, "lit 1234", rd_data, 16'h1234);

            access(1, 0, 16'h0005, 16'hA5A5, 0, 0);
            access(0, 0, 16'h0405, 16'h0000, 0, 0);
            chk(L, "lit alias", rd_data, 16'hA5A5);

            access(0, 0, 16'h0040, 16'h0000, 0, 0);
            access(1, 0, 16'h0040, 16'h5A5A, 0, 0);
            access(0, 0, 16'h0040, 16'h0000, 0, 0);
            chk(L, "lit unwritten", rd_data, 16'h5A5A);

            access(1, 0, 16'h0007, 16'h0BAD, 1, 0);
            access(0, 0, 16'h0007, 16'h0000, 1, 2);
            chk(L, "lit toggle", rd_data, 16'h0BAD);

            access(1, 0, 16'h0020, 16'h1111, 0, 0);
            launch(1, 0, 16'h0020, 16'h7777);
            @(posedge clk);
            #1;
            rst_n  = 1'b0;
            we     = 1'b0;
            re     = 1'b0;
            active = 1'b0;
            #1;
            chk(L, "lit rst busy", busy, 0);
            chk(L, "lit rst rdy", rdy, 0);
            chk(L, "lit rst data", rd_data, 0);
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            access(0, 0, 16'h0020, 16'h0000, 0, 0);
            chk(L, "lit rst keep", rd_data, 16'h1111);

            for (int n = 0; n < 80; n++) begin
                a = 16'($urandom_range(0, 15))
                  | (16'($urandom_range(0, 63)) << 10);
                d    = 16'($urandom);
                wr   = 1'($urandom_range(0, 1));
                both = wr && ($urandom_range(0, 3) == 0);
                tog  = 1'($urandom_range(0, 1));
                access(wr, both, a, d, tog,
                       ($urandom_range(0, 3) == 0) ? 2 : 0);
            end
            repeat (3) @(posedge clk);
            done[g] = 1'b1;
        end
    end

    initial begin
        int w;
        for (w = 0; w < 50000; w++) begin
            if (done[0] && done[1]) break;
            @(posedge clk);
        end
        if (!(done[0] && done[1])) begin
            checks++;
            errors++;
            $display("FAIL timeout: done=%0b%0b want 11",
                     done[0], done[1]);
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
